// File: rtl/in_packet_fifo_pkg.sv
// Shared router-port definitions for the input packet buffer.
//  FLIT_W / FIFO_DEPTH / FIFO_AF_LEVEL : default buffer geometry.
//  flit_t : flit field layout; route compute downstream reads dest/src.
package in_packet_fifo_pkg;

    localparam int FLIT_W        = 64;
    localparam int FIFO_DEPTH    = 4;
    localparam int FIFO_AF_LEVEL = 3;

    // Field offsets within a flit (LSB positions).
    localparam int PAYLOAD_LSB = 0;
    localparam int SRC_LSB     = 48;
    localparam int DEST_LSB    = 56;

    typedef struct packed {
        logic [7:0]  dest;
        logic [7:0]  src;
        logic [47:0] payload;
    } flit_t;

endpackage

// File: rtl/in_packet_fifo_mem.sv
// Flit storage array for in_packet_fifo.
//  clk   : write clock
//  we    : write enable
//  waddr : write address
//  wdata : flit to store
//  raddr : read address
//  rdata : flit at raddr (asynchronous read)
// Contents are never reset; the pointers in the parent decide what is valid.
module in_packet_fifo_mem
    import in_packet_fifo_pkg::*;
#(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/in_packet_fifo.sv
// Router input-port packet buffer, first-word-fall-through.
//  clk, reset  : clock, synchronous active-high reset
//  wr_en       : write request (writer honours full)
//  wr_data     : flit to store
//  full        : no free entry
//  almost_full : count >= AF_LEVEL
//  rd_en       : pop head flit
//  rd_data     : head flit, 0 when empty
//  empty       : no stored flit
//  count       : occupancy 0..DEPTH
//  overflow    : sticky, write attempted while full
//  underflow   : sticky, read attempted while empty
module in_packet_fifo
    import in_packet_fifo_pkg::*;
#(
    parameter int DATA_W   = FLIT_W,
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [PTR_W-1:0] AF_CNT = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] ONE    = PTR_W'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] mem_rdata;

    // Flags come from registered state only; wr_en/rd_en never feed them.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full = (count >= AF_CNT);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Memory write is gated by reset so a reset cycle has no side effects.
    in_packet_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && !reset),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (mem_rdata)
    );

    assign rd_data = empty ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE;
            if (rd_acc) rd_ptr <= rd_ptr + ONE;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_in_packet_fifo.sv
// Self-checking bench for in_packet_fifo: a queue scoreboard holds the
// expected FIFO contents; every pop compares the head against it.
module tb_in_packet_fifo;

    localparam int DW    = 64;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en, rd_en;
    logic [DW-1:0] wr_data;
    logic          full, almost_full, empty, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [2:0]    count;

    int n_checks = 0;
    int n_errs   = 0;

    logic [DW-1:0] exp_q[$];
    logic          m_ovf, m_unf;

    always #5 clk = ~clk;

    in_packet_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard state.
    task automatic check_status(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, "_count"}, DW'(count), DW'(n));
        chk({tag, "_empty"}, DW'(empty), DW'(n == 0));
        chk({tag, "_full"},  DW'(full),  DW'(n == DEPTH));
        chk({tag, "_af"},    DW'(almost_full), DW'(n >= AF));
        chk({tag, "_ovf"},   DW'(overflow),  DW'(m_ovf));
        chk({tag, "_unf"},   DW'(underflow), DW'(m_unf));
        chk({tag, "_data"},  rd_data, (n == 0) ? '0 : exp_q[0]);
    endtask

    // One clock with the given request; head compared before the pop edge.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re, input string tag);
        bit w_ok, r_ok;
        wr_en = we; wr_data = wd; rd_en = re;
        @(negedge clk);
        r_ok = re && (exp_q.size() > 0);
        w_ok = we && (exp_q.size() < DEPTH);
        if (r_ok) chk({tag, "_head"}, rd_data, exp_q[0]);
        @(posedge clk); #1;
        if (r_ok) void'(exp_q.pop_front());
        if (w_ok) exp_q.push_back(wd);
        if (we && !w_ok) m_ovf = 1'b1;
        if (re && !r_ok) m_unf = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 64'hDEAD;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        m_ovf = 1'b0; m_unf = 1'b0;

        // 1. reset held with requests asserted
        pulse_reset(2);
        check_status("rst");

        // 2. fill then drain
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 64'hA0 + 64'(i), 1'b0, "fill");
            check_status("fill");
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, 1'b1, "drain");
            check_status("drain");
        end

        // 3. steady stream at count=2 across several wraps
        cycle(1'b1, 64'h1, 1'b0, "wrap");
        cycle(1'b1, 64'h2, 1'b0, "wrap");
        for (int i = 3; i <= 10; i++) begin
            cycle(1'b1, 64'(i), 1'b1, "wrap");
            check_status("wrap");
        end
        cycle(1'b0, '0, 1'b1, "wrap");
        cycle(1'b0, '0, 1'b1, "wrap");
        check_status("wrap_end");

        // 4. simultaneous push/pop while full
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'hA0 + 64'(i), 1'b0, "full");
        check_status("full_pre");
        cycle(1'b1, 64'hFF, 1'b1, "full_sim");
        check_status("full_sim");
        chk("full_sim_ovf_set", DW'(overflow), DW'(1));
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, "full_drain");
        check_status("full_drain");

        // 5. simultaneous push/pop while empty
        cycle(1'b1, 64'h55, 1'b1, "empty_sim");
        check_status("empty_sim");
        chk("empty_sim_data", rd_data, 64'h55);
        chk("empty_sim_unf_set", DW'(underflow), DW'(1));

        // 6. reset with data in flight
        cycle(1'b1, 64'h66, 1'b0, "mid");
        cycle(1'b1, 64'h67, 1'b0, "mid");
        check_status("mid_pre");
        pulse_reset(1);
        check_status("mid_rst");
        cycle(1'b1, 64'h77, 1'b0, "post");
        check_status("post");
        cycle(1'b0, '0, 1'b1, "post");
        check_status("post_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
